// File: rtl/cam_adder_pipe_if.sv
// Operand/result handshake bundle for cam_adder_pipe.
interface cam_adder_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH+1:0] sum;

  modport master (
    output in_valid, a, b, c, out_ready,
    input  in_ready, out_valid, sum
  );

  modport slave (
    input  in_valid, a, b, c, out_ready,
    output in_ready, out_valid, sum
  );
endinterface

// File: rtl/cam_adder_pipe.sv
// Three-operand adder built only from a loadable 8-entry full-adder table:
// one carry-save lookup pass, then a GROUP-bits-per-cycle ripple pass.
// Optional reference checker enabled by defining CAM_ADDER_SELF_CHECK_EN.
module cam_adder_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GROUP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tbl_we,
  input  logic [2:0]  tbl_addr,
  input  logic [1:0]  tbl_data,
  output logic        tbl_loaded,
  output logic        tbl_wr_err,
`ifdef CAM_ADDER_SELF_CHECK_EN
  output logic        chk_mismatch,
  output logic [15:0] chk_err_cnt,
`endif
  cam_adder_pipe_if.slave bus
);

  localparam int unsigned NGRP = (WIDTH + GROUP) / GROUP;
  localparam int unsigned GW   = $clog2(NGRP + 1);
  localparam int unsigned IW   = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CSA, RIPPLE, DONE} state_t;

  state_t           state, state_nx;
  logic [1:0]       tbl [8];
  logic [7:0]       written;
  logic [WIDTH-1:0] op_a, op_b, op_c;
  logic [WIDTH-1:0] csa_s, csa_cy;
  logic [WIDTH:0]   s_vec, c_vec, r_vec, r_nx;
  logic             rc, rc_nx;
  logic [GW-1:0]    g;
  logic [WIDTH+1:0] sum_q;
  logic             accept, last_grp, tbl_wr_ok;

  assign tbl_loaded    = &written;
  assign bus.in_ready  = (state == IDLE) && tbl_loaded && !tbl_we;
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_q;
  assign accept        = bus.in_valid && bus.in_ready;
  assign last_grp      = (g == GW'(NGRP - 1));
  assign tbl_wr_ok     = tbl_we && (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = CSA;
      CSA:     state_nx = RIPPLE;
      RIPPLE:  if (last_grp) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Table storage carries no reset; the bitmap gates its use.
  always_ff @(posedge clk) begin
    if (tbl_wr_ok) tbl[tbl_addr] <= tbl_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      written    <= '0;
      tbl_wr_err <= 1'b0;
    end else begin
      tbl_wr_err <= tbl_we && (state != IDLE);
      if (tbl_wr_ok) written[tbl_addr] <= 1'b1;
    end
  end

  always_comb begin
    csa_s  = '0;
    csa_cy = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      {csa_cy[i], csa_s[i]} = tbl[{op_a[i], op_b[i], op_c[i]}];
    end
  end

  // Resolve the current group, carry chained bit to bit within the cycle.
  always_comb begin
    int unsigned j;
    logic [IW-1:0] jx;
    r_nx  = r_vec;
    rc_nx = rc;
    j     = 0;
    jx    = '0;
    for (int unsigned k = 0; k < GROUP; k++) begin
      j = 32'(g) * GROUP + k;
      if (j <= WIDTH) begin
        jx = IW'(j);
        {rc_nx, r_nx[jx]} = tbl[{s_vec[jx], c_vec[jx], rc_nx}];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      op_c  <= '0;
      s_vec <= '0;
      c_vec <= '0;
      r_vec <= '0;
      rc    <= 1'b0;
      g     <= '0;
      sum_q <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_a <= bus.a;
          op_b <= bus.b;
          op_c <= bus.c;
        end
        CSA: begin
          s_vec <= {1'b0, csa_s};
          c_vec <= {csa_cy, 1'b0};
          r_vec <= '0;
          rc    <= 1'b0;
          g     <= '0;
        end
        RIPPLE: begin
          r_vec <= r_nx;
          rc    <= rc_nx;
          g     <= g + GW'(1);
          if (last_grp) sum_q <= {rc_nx, r_nx};
        end
        default: ;
      endcase
    end
  end

`ifdef CAM_ADDER_SELF_CHECK_EN
  logic [WIDTH+1:0] ref_sum;
  logic             mism_nx;

  assign ref_sum = {2'b00, op_a} + {2'b00, op_b} + {2'b00, op_c};
  assign mism_nx = ({rc_nx, r_nx} != ref_sum);

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_mismatch <= 1'b0;
      chk_err_cnt  <= '0;
    end else if (state == RIPPLE && last_grp) begin
      chk_mismatch <= mism_nx;
      if (mism_nx && chk_err_cnt != '1) chk_err_cnt <= chk_err_cnt + 16'd1;
    end else if (state_nx != DONE) begin
      chk_mismatch <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_cam_adder_pipe.sv
// Self-checking bench for cam_adder_pipe: vector table on GROUP=4, plus
// reset/backpressure/table-write corner cases and GROUP=1/33 random sweeps.
module tb_cam_adder_pipe;
  localparam int unsigned W = 32;
  localparam int LAT4  = 1 + (W + 4) / 4;
  localparam int LAT1  = 1 + (W + 1) / 1;
  localparam int LAT33 = 1 + (W + 33) / 33;

  logic       clk = 1'b0;
  logic       rst;
  logic       tbl_we;
  logic [2:0] tbl_addr;
  logic [1:0] tbl_data;
  logic       tbl_loaded, tbl_wr_err, tl1, te1, tl33, te33;

  int checks = 0;
  int fails  = 0;
  logic [W+1:0] sb[$], sb1[$], sb33[$];

  always #5 clk = ~clk;

  cam_adder_pipe_if #(.WIDTH(W)) bus ();
  cam_adder_pipe_if #(.WIDTH(W)) bus1 ();
  cam_adder_pipe_if #(.WIDTH(W)) bus33 ();

`ifdef CAM_ADDER_SELF_CHECK_EN
  logic chk_mismatch, cm1, cm33;
  logic [15:0] chk_err_cnt, cc1, cc33;
`endif

  cam_adder_pipe #(.WIDTH(W), .GROUP(4)) dut (
    .clk(clk), .rst(rst), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .tbl_loaded(tbl_loaded), .tbl_wr_err(tbl_wr_err),
`ifdef CAM_ADDER_SELF_CHECK_EN
    .chk_mismatch(chk_mismatch), .chk_err_cnt(chk_err_cnt),
`endif
    .bus(bus)
  );

  cam_adder_pipe #(.WIDTH(W), .GROUP(1)) dut1 (
    .clk(clk), .rst(rst), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .tbl_loaded(tl1), .tbl_wr_err(te1),
`ifdef CAM_ADDER_SELF_CHECK_EN
    .chk_mismatch(cm1), .chk_err_cnt(cc1),
`endif
    .bus(bus1)
  );

  cam_adder_pipe #(.WIDTH(W), .GROUP(33)) dut33 (
    .clk(clk), .rst(rst), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .tbl_loaded(tl33), .tbl_wr_err(te33),
`ifdef CAM_ADDER_SELF_CHECK_EN
    .chk_mismatch(cm33), .chk_err_cnt(cc33),
`endif
    .bus(bus33)
  );

  typedef struct {
    logic [W-1:0] a, b, c;
    logic [W+1:0] exp;
    int           hold;
    int           inject;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_std();
    int unsigned order [9];
    logic [2:0] n;
    order = '{0, 1, 2, 3, 4, 5, 6, 0, 7};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("ready_low_during_load", bus.in_ready, 0);
      check("loaded_low_during_load", tbl_loaded, 0);
      n = 3'(order[i]);
      tbl_we   = 1'b1;
      tbl_addr = n;
      tbl_data = {($countones(n) >= 2), ^n};
    end
    @(negedge clk);
    check("loaded_after_8th", tbl_loaded, 1);
    check("ready_low_while_we", bus.in_ready, 0);
    tbl_we = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] ta, tb_, tc, input logic [W+1:0] texp,
                        input int hold, input int inject);
    int lat;
    logic [W+1:0] held;
    lat = 0;
    @(negedge clk);
    while (!bus.in_ready && lat < 50) begin @(negedge clk); lat++; end
    check("ready_before_accept", bus.in_ready, 1);
    bus.a = ta; bus.b = tb_; bus.c = tc;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    sb.push_back(texp);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      if (lat == inject) begin tbl_we = 1'b1; tbl_addr = 3'd3; tbl_data = 2'd0; end
      @(negedge clk);
      lat++;
      if (inject >= 0 && lat == inject + 1) begin
        check("wr_err_pulse", tbl_wr_err, 1);
        tbl_we = 1'b0;
      end
      if (inject >= 0 && lat == inject + 2) check("wr_err_single", tbl_wr_err, 0);
    end
    check("latency", lat, LAT4);
    held = bus.sum;
`ifdef CAM_ADDER_SELF_CHECK_EN
    check("chk_mismatch", chk_mismatch, texp != ({2'b00, ta} + {2'b00, tb_} + {2'b00, tc}));
`endif
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.a = $urandom(); bus.b = $urandom(); bus.c = $urandom();
      @(negedge clk);
      check("bp_valid_held", bus.out_valid, 1);
      check("bp_sum_stable", bus.sum, held);
      check("bp_ready_low", bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("result", bus.sum, sb.pop_front());
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("valid_cleared", bus.out_valid, 0);
    check("ready_after_handshake", bus.in_ready, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [8];
    int w, lat, l1, l33, seen;
    logic d1, d33;
    logic [W+1:0] s1, s33, e;
    logic [W-1:0] ra, rb, rcv;

    rst = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.c = '0; bus.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.c = '0; bus1.out_ready = 1'b1;
    bus33.in_valid = 1'b0; bus33.a = '0; bus33.b = '0; bus33.c = '0; bus33.out_ready = 1'b1;

    vt[0] = '{32'd1, 32'd2, 32'd3, 34'd6, 0, -1};
    vt[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34'h2FFFFFFFD, 0, -1};
    vt[2] = '{32'h80000000, 32'h80000000, 32'h0, 34'h100000000, 5, -1};
    vt[3] = '{32'd5, 32'd7, 32'd9, 34'd21, 0, 3};
    for (int i = 4; i < 8; i++) begin
      vt[i].a = $urandom(); vt[i].b = $urandom(); vt[i].c = $urandom();
      vt[i].exp = {2'b00, vt[i].a} + {2'b00, vt[i].b} + {2'b00, vt[i].c};
      vt[i].hold = i - 4;
      vt[i].inject = -1;
    end

    repeat (2) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_loaded", tbl_loaded, 0);
    check("rst_wr_err", tbl_wr_err, 0);
    rst = 1'b0;

    load_std();
    for (int i = 0; i < 8; i++) run_op(vt[i].a, vt[i].b, vt[i].c, vt[i].exp, vt[i].hold, vt[i].inject);

    // Corrupt entry 3 while idle: 0+1+1 then resolves to all-zero lookups.
    @(negedge clk);
    tbl_we = 1'b1; tbl_addr = 3'd3; tbl_data = 2'd0;
    @(negedge clk);
    check("idle_write_no_err", tbl_wr_err, 0);
    tbl_we = 1'b0;
    run_op(32'd0, 32'd1, 32'd1, 34'd0, 0, -1);
`ifdef CAM_ADDER_SELF_CHECK_EN
    check("chk_err_cnt", chk_err_cnt, 1);
`endif

    // Reset while the ripple counter sits at group 4.
    @(negedge clk);
    w = 0;
    while (!bus.in_ready && w < 50) begin @(negedge clk); w++; end
    bus.a = 32'd10; bus.b = 32'd20; bus.c = 32'd30; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    sb.push_back(34'd60);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_back());
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_loaded", tbl_loaded, 0);
    check("abort_in_ready", bus.in_ready, 0);
`ifdef CAM_ADDER_SELF_CHECK_EN
    check("abort_chk_cnt", chk_err_cnt, 0);
`endif
    seen = 0;
    repeat (20) begin @(negedge clk); if (bus.out_valid) seen = 1; end
    check("no_result_after_abort", seen, 0);
    bus.out_ready = 1'b0;

    load_std();
    check("g1_loaded", tl1, 1);
    check("g33_loaded", tl33, 1);

    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      w = 0;
      while (!(bus1.in_ready && bus33.in_ready) && w < 100) begin @(negedge clk); w++; end
      check("sweep_ready", bus1.in_ready & bus33.in_ready, 1);
      ra = $urandom(); rb = $urandom(); rcv = $urandom();
      e = {2'b00, ra} + {2'b00, rb} + {2'b00, rcv};
      bus1.a = ra;  bus1.b = rb;  bus1.c = rcv;  bus1.in_valid = 1'b1;
      bus33.a = ra; bus33.b = rb; bus33.c = rcv; bus33.in_valid = 1'b1;
      sb1.push_back(e);
      sb33.push_back(e);
      @(negedge clk);
      bus1.in_valid = 1'b0;
      bus33.in_valid = 1'b0;
      lat = 0; d1 = 1'b0; d33 = 1'b0; l1 = -1; l33 = -1; s1 = '0; s33 = '0;
      while (!(d1 && d33) && lat < 80) begin
        if (!d1 && bus1.out_valid) begin d1 = 1'b1; l1 = lat; s1 = bus1.sum; end
        if (!d33 && bus33.out_valid) begin d33 = 1'b1; l33 = lat; s33 = bus33.sum; end
        if (!(d1 && d33)) begin @(negedge clk); lat++; end
      end
      check("g1_sum", s1, sb1.pop_front());
      check("g33_sum", s33, sb33.pop_front());
      check("g1_latency", l1, LAT1);
      check("g33_latency", l33, LAT33);
    end
    check("g1_no_wr_err", te1, 0);
    check("g33_no_wr_err", te33, 0);
`ifdef CAM_ADDER_SELF_CHECK_EN
    check("g1_chk_cnt", cc1, 0);
    check("g33_chk_cnt", cc33, 0);
    check("g1_chk_mismatch", cm1, 0);
    check("g33_chk_mismatch", cm33, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
